// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: owns the PC, fetches from a combinational imem and
// queues {pc, instr} for decode. Define IFETCH_PERF_EN to add saturating perf counters.
module ifetch_queue #(
  parameter int          DEPTH        = 2,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic [31:0] out_pc_plus8
`ifdef IFETCH_PERF_EN
  ,
  output logic [15:0] perf_fetch_cnt,
  output logic [15:0] perf_stall_cnt,
  output logic [15:0] perf_flush_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]      instr_q [DEPTH];
  logic [31:0]      addr_q  [DEPTH];

  logic pop;
  logic push;

  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  // A pop frees the head slot in the same edge, so a full queue can still accept a fetch.
  assign push      = !redirect_valid & ((count_q < FULL) | pop);
  assign imem_addr = pc_q;

  always_comb begin
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect_valid) begin
      pc_d     = {redirect_target[31:2], 2'b00};
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q     <= RESET_VECTOR;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Payload storage is not reset; stale entries are masked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr_q] <= imem_rd;
      addr_q[wr_ptr_q]  <= pc_q;
    end
  end

  assign out_instr    = out_valid ? instr_q[rd_ptr_q] : '0;
  assign out_pc       = out_valid ? addr_q[rd_ptr_q] : '0;
  assign out_pc_plus4 = out_valid ? addr_q[rd_ptr_q] + 32'd4 : '0;
  assign out_pc_plus8 = out_valid ? addr_q[rd_ptr_q] + 32'd8 : '0;

`ifdef IFETCH_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] fetch_cnt_q, stall_cnt_q, flush_cnt_q;
  logic        stall;

  assign stall = (count_q == FULL) & !pop & !redirect_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (push)           fetch_cnt_q <= sat_inc(fetch_cnt_q);
      if (stall)          stall_cnt_q <= sat_inc(stall_cnt_q);
      if (redirect_valid) flush_cnt_q <= sat_inc(flush_cnt_q);
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction-fetch front end for the SimpleARM core.
- Owns the PC and drives the word-aligned address into the combinational instruction memory, which returns rd in the same cycle.
- Buffers fetched words in a small in-order queue and presents them to decode through a valid/ready handshake.
- Accepts redirects (B/BL/PC writes) from execute, flushing everything already fetched.

Parameters:
- DEPTH, 2, queue entries; power of two, 2..8.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  core clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- imem_addr  out  32  instruction memory address; always equals pc, bits [1:0] = 0.
- imem_rd  in  32  instruction word for imem_addr, valid in the same cycle.
- redirect_valid  in  1  execute requests a fetch redirect this cycle.
- redirect_target  in  32  new PC; bits [1:0] are ignored and forced to 0.
- out_valid  out  1  queue head holds a valid instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  32  head instruction word.
- out_pc  out  32  address of the head instruction.
- out_pc_plus4  out  32  out_pc+4; link value for BL.
- out_pc_plus8  out  32  out_pc+8; architectural PC read value.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - pc = RESET_VECTOR, queue count = 0, read/write pointers = 0.
  - out_valid = 0; out_instr, out_pc, out_pc_plus4 and out_pc_plus8 read as 0 while empty.
  - imem_addr = RESET_VECTOR.
- Reset release: the first fetch occurs on the first rising edge after reset_n=1.
- Pop: pop = out_valid & out_ready. The head is consumed at the clock edge.
- Push condition: push = !redirect_valid & (count<DEPTH | pop).
  - Writes {pc, imem_rd} at the tail.
  - Sets pc <= pc+4, computed mod 2^32: 0xFFFF_FFFC wraps to 0x0000_0000.
- Full with no pop:
  - No push; pc holds; imem_addr holds.
  - imem_rd is re-read next cycle. No word is dropped or duplicated.
- Simultaneous push and pop when full: both occur and count is unchanged.
- Redirect (redirect_valid=1) has priority over push and pop:
  - count <= 0 and both pointers <= 0.
  - pc <= {redirect_target[31:2], 2'b00}.
  - No push this cycle.
  - out_valid is 0 in the following cycle.
  - The first word from the new target appears at the output 2 cycles after redirect assertion (redirect edge, then fetch edge).
- Redirect while out_ready=1 and out_valid=1 in the same cycle: the head is treated as consumed by decode. The block makes no distinction; the queue is flushed regardless.
- Output timing:
  - out_valid = (count != 0).
  - Head fields come directly from queue storage, with no combinational path from imem_rd to the out_* ports.
  - Fetch-to-output latency is 1 cycle when the queue is empty.
- Throughput: 1 instruction/cycle sustained while out_ready=1.
- Handshake rule: the head must stay stable while out_valid=1 and out_ready=0, unless a redirect occurs.
- Width: count is $clog2(DEPTH)+1 bits; pointers are $clog2(DEPTH) bits and wrap naturally.
- Reset mid-operation: all state returns to reset values immediately; no in-flight word survives.

Optional Feature:
- Macro: IFETCH_PERF_EN.
- Defined: adds three output ports, each 16 bits, saturating at 0xFFFF and cleared by reset_n:
  - perf_fetch_cnt: increments on push.
  - perf_stall_cnt: increments on cycles with count==DEPTH & !pop & !redirect_valid.
  - perf_flush_cnt: increments on each redirect_valid cycle.
- Not defined: these ports and the counter logic are absent. Functional behaviour is identical.

Test Plan:
- Reset then stream:
  - Program: mem[0]=EB000000, mem[1]=E2800008, mem[2]=E0411001; out_ready=1.
  - Required: out_pc 0x0,0x4,0x8 on consecutive cycles starting 1 cycle after reset release.
  - Required: out_instr EB000000, E2800008, E0411001; out_pc_plus8 = 0x8 for the first word.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles (DEPTH=2).
  - Required: count stops at 2; imem_addr holds at 0x8; head stays pc 0x0.
  - Stimulus: release out_ready.
  - Required: the sequence 0x0,0x4,0x8,0xC continues with no gaps or duplicates.
- BL redirect:
  - Stimulus: redirect_valid=1, target 0x8 while the queue holds pc 0x4/0x8.
  - Required: next cycle out_valid=0; the following cycle out_pc=0x8, out_instr=E0411001.
  - Required: the link value seen by decode for BL at 0x0 is out_pc_plus4=0x4.
- Unaligned target:
  - Stimulus: redirect_target=0x0000_000E.
  - Required: imem_addr=0x0000_000C; out_pc=0xC.
- Wrap and async reset:
  - Stimulus: redirect to 0xFFFF_FFFC.
  - Required: the next fetch address is 0x0000_0000.
  - Stimulus: assert reset_n=0 mid-cycle with a full queue.
  - Required: out_valid=0 immediately; imem_addr=RESET_VECTOR.
- IFETCH_PERF_EN build:
  - Stimulus: 10 pushes, 3 stall cycles, 2 redirects.
  - Required: counters read 10/3/2.
  - Required: saturation holds 0xFFFF after 70000 pushes.
